// File: rtl/dual_mic_frontend.sv
// Dual-microphone acquisition front end. Boxcar-decimates two offset-binary ADC streams into
// signed samples and strobes them out no more often than every min_gap cycles.
module dual_mic_frontend #(
  parameter int unsigned wordsize   = 8,
  parameter int unsigned adc_width  = 12,
  parameter int unsigned log2_decim = 2,
  parameter int unsigned min_gap    = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 adc_valid,
  input  logic [adc_width-1:0] adc_main,
  input  logic [adc_width-1:0] adc_sub,
  output logic [wordsize-1:0]  main,
  output logic [wordsize-1:0]  sub,
  output logic                 start_sample,
  output logic                 start,
  output logic                 overrun
);

  localparam int unsigned acc_w   = adc_width + log2_decim;
  localparam int unsigned shift_w = adc_width - wordsize;
  localparam int unsigned cnt_w   = (log2_decim == 0) ? 1 : log2_decim;
  localparam int unsigned gap_w   = $clog2(min_gap);

  localparam logic [cnt_w-1:0] cnt_last = cnt_w'((2 ** log2_decim) - 1);
  localparam logic [gap_w-1:0] gap_max  = gap_w'(min_gap - 1);
  localparam logic signed [acc_w:0] out_max = (acc_w + 1)'((2 ** (wordsize - 1)) - 1);
  localparam logic signed [acc_w:0] out_min = (acc_w + 1)'(-(2 ** (wordsize - 1)));
  localparam logic signed [acc_w:0] round_k = (acc_w + 1)'(2 ** (shift_w - 1));

  typedef enum logic {IDLE, ACCUM} state_e;

  // Offset-binary to two's complement, sign-extended to accumulator width.
  function automatic logic signed [acc_w-1:0] conv(input logic [adc_width-1:0] w);
    logic signed [adc_width-1:0] t;
    t = $signed(w ^ {1'b1, {(adc_width - 1){1'b0}}});
    return acc_w'(t);
  endfunction

  // Average, round to nearest, drop low bits and saturate to the output word.
  function automatic logic [wordsize-1:0] scale(input logic signed [acc_w-1:0] sum);
    logic signed [acc_w-1:0] avg;
    logic signed [acc_w:0]   r;
    logic signed [acc_w:0]   q;
    avg = sum >>> log2_decim;
    r   = (acc_w + 1)'(avg) + round_k;
    q   = r >>> shift_w;
    if (q > out_max)      q = out_max;
    else if (q < out_min) q = out_min;
    return wordsize'(q);
  endfunction

  state_e                  state_q, state_d;
  logic signed [acc_w-1:0] acc_m_q, acc_m_d, acc_s_q, acc_s_d;
  logic [cnt_w-1:0]        cnt_q, cnt_d;
  logic [gap_w-1:0]        gap_q, gap_d;
  logic [wordsize-1:0]     main_q, main_d, sub_q, sub_d;
  logic                    strobe_q, strobe_d;
  logic                    start_q, start_d;
  logic                    overrun_q, overrun_d;
  logic signed [acc_w-1:0] sum_m, sum_s;

  always_comb begin
    state_d   = state_q;
    acc_m_d   = acc_m_q;
    acc_s_d   = acc_s_q;
    cnt_d     = cnt_q;
    main_d    = main_q;
    sub_d     = sub_q;
    strobe_d  = 1'b0;
    start_d   = start_q;
    overrun_d = overrun_q;
    sum_m     = acc_m_q + conv(adc_main);
    sum_s     = acc_s_q + conv(adc_sub);

    case (state_q)
      IDLE: begin
        acc_m_d   = '0;
        acc_s_d   = '0;
        cnt_d     = '0;
        start_d   = 1'b0;
        overrun_d = 1'b0;
        if (enable) state_d = ACCUM;
      end
      ACCUM: begin
        if (!enable) begin
          state_d   = IDLE;
          acc_m_d   = '0;
          acc_s_d   = '0;
          cnt_d     = '0;
          start_d   = 1'b0;
          overrun_d = 1'b0;
        end else if (adc_valid) begin
          if (cnt_q == cnt_last) begin
            acc_m_d = '0;
            acc_s_d = '0;
            cnt_d   = '0;
            // Completion inside the gap window is dropped rather than delayed.
            if (gap_q >= gap_max) begin
              strobe_d = 1'b1;
              start_d  = 1'b1;
              main_d   = scale(sum_m);
              sub_d    = scale(sum_s);
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            acc_m_d = sum_m;
            acc_s_d = sum_s;
            cnt_d   = cnt_w'(cnt_q + 1'b1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (strobe_d)              gap_d = '0;
    else if (gap_q >= gap_max) gap_d = gap_max;
    else                       gap_d = gap_w'(gap_q + 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_m_q   <= '0;
      acc_s_q   <= '0;
      cnt_q     <= '0;
      gap_q     <= gap_max;
      main_q    <= '0;
      sub_q     <= '0;
      strobe_q  <= 1'b0;
      start_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_m_q   <= acc_m_d;
      acc_s_q   <= acc_s_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      main_q    <= main_d;
      sub_q     <= sub_d;
      strobe_q  <= strobe_d;
      start_q   <= start_d;
      overrun_q <= overrun_d;
    end
  end

  assign main         = main_q;
  assign sub          = sub_q;
  assign start_sample = strobe_q;
  assign start        = start_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_dual_mic_frontend.sv
// Bench for dual_mic_frontend: directed scenarios plus random traffic, each cycle compared
// against an arithmetic model of the decimator, gap rule and status flags.
module tb_dual_mic_frontend;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        adc_valid;
  logic [11:0] adc_main;
  logic [11:0] adc_sub;
  logic [7:0]  main;
  logic [7:0]  sub;
  logic        start_sample;
  logic        start;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  // model state
  int m_cyc = 0;
  int m_last = -100000;
  bit m_active = 0;
  int m_n = 0;
  int m_sum_m = 0;
  int m_sum_s = 0;
  int m_main = 0;
  int m_sub = 0;
  bit m_strobe = 0;
  bit m_start = 0;
  bit m_ovr = 0;

  dual_mic_frontend #(
    .wordsize(8), .adc_width(12), .log2_decim(2), .min_gap(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_valid(adc_valid),
    .adc_main(adc_main), .adc_sub(adc_sub), .main(main), .sub(sub),
    .start_sample(start_sample), .start(start), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // 4-sample mean of ADC codes centred at 2048, rounded and scaled to 8 bits.
  function automatic int to_out(input int sum);
    int v;
    v = fdiv(fdiv(sum, 4) + 8, 16);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic model_reset();
    m_last = -100000; m_active = 0; m_n = 0; m_sum_m = 0; m_sum_s = 0;
    m_main = 0; m_sub = 0; m_strobe = 0; m_start = 0; m_ovr = 0;
  endtask

  task automatic model_edge();
    m_cyc++;
    m_strobe = 0;
    if (!m_active || !enable) begin
      m_n = 0; m_sum_m = 0; m_sum_s = 0; m_start = 0; m_ovr = 0;
    end else if (adc_valid) begin
      m_sum_m += int'(adc_main) - 2048;
      m_sum_s += int'(adc_sub) - 2048;
      m_n++;
      if (m_n == 4) begin
        if (m_cyc - m_last >= 40) begin
          m_strobe = 1; m_start = 1; m_last = m_cyc;
          m_main = to_out(m_sum_m);
          m_sub = to_out(m_sum_s);
        end else begin
          m_ovr = 1;
        end
        m_n = 0; m_sum_m = 0; m_sum_s = 0;
      end
    end
    m_active = enable;
  endtask

  task automatic compare_all();
    check("start_sample", int'(start_sample), int'(m_strobe));
    check("start", int'(start), int'(m_start));
    check("overrun", int'(overrun), int'(m_ovr));
    check("main", int'($signed(main)), m_main);
    check("sub", int'($signed(sub)), m_sub);
  endtask

  task automatic cycle(input bit en, input bit v, input logic [11:0] am, input logic [11:0] as_);
    enable = en; adc_valid = v; adc_main = am; adc_sub = as_;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input bit en, input int n);
    for (int i = 0; i < n; i++) cycle(en, 1'b0, 12'h000, 12'h000);
  endtask

  int strobes;
  logic [11:0] rm, rs;
  bit ren;

  initial begin
    rst_n = 1'b0; enable = 1'b0; adc_valid = 1'b0; adc_main = '0; adc_sub = '0;
    #12;
    compare_all();
    @(negedge clk) rst_n = 1'b1;
    idle(1'b0, 2);

    // mid-scale in -> zero out; start rises with the strobe
    idle(1'b1, 2);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 12'h800, 12'h800);
    check("first_strobe", int'(start_sample), 1);
    check("first_start", int'(start), 1);
    idle(1'b1, 45);

    // full-scale both directions saturate
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 12'hFFF, 12'h000);
    check("sat_main", int'($signed(main)), 127);
    check("sat_sub", int'($signed(sub)), -128);
    idle(1'b1, 45);

    // rounding of small positive values
    cycle(1'b1, 1'b1, 12'h800, 12'h810);
    cycle(1'b1, 1'b1, 12'h808, 12'h810);
    cycle(1'b1, 1'b1, 12'h810, 12'h810);
    cycle(1'b1, 1'b1, 12'h818, 12'h810);
    check("round_main", int'($signed(main)), 1);
    check("round_sub", int'($signed(sub)), 1);
    idle(1'b1, 45);

    // continuous valids: strobes 40 apart, overrun after first drop
    strobes = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 1'b1, 12'($urandom), 12'($urandom));
      if (start_sample) strobes++;
    end
    check("gap_strobes", strobes, 5);
    check("gap_overrun", int'(overrun), 1);
    idle(1'b1, 45);

    // partial accumulation discarded across an enable drop
    cycle(1'b1, 1'b1, 12'hFFF, 12'hFFF);
    cycle(1'b1, 1'b1, 12'hFFF, 12'hFFF);
    idle(1'b0, 3);
    check("idle_start", int'(start), 0);
    idle(1'b1, 1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 12'h810, 12'h810);
    check("partial_main", int'($signed(main)), 1);
    check("partial_strobe", int'(start_sample), 1);

    // async reset mid-accumulation with start and overrun set
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 12'h900, 12'h700);
    check("pre_rst_ovr", int'(overrun), 1);
    cycle(1'b1, 1'b1, 12'h900, 12'h700);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk) rst_n = 1'b1;
    idle(1'b1, 1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 12'hA00, 12'h600);
    check("post_rst_strobe", int'(start_sample), 1);
    check("post_rst_main", int'($signed(main)), 32);
    check("post_rst_sub", int'($signed(sub)), -32);

    // random traffic
    ren = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) ren = ~ren;
      case ($urandom_range(0, 3))
        0: begin rm = 12'hFFF; rs = 12'h000; end
        1: begin rm = 12'($urandom_range(12'h7F0, 12'h810)); rs = 12'($urandom_range(12'h7F0, 12'h810)); end
        default: begin rm = 12'($urandom); rs = 12'($urandom); end
      endcase
      cycle(ren, 1'($urandom_range(0, 99) < 60), rm, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dual_mic_frontend.md
Name: dual_mic_frontend

Overview:
- Upstream acquisition stage for the two-microphone noise reducer.
- Captures raw ADC words from the main and reference (noise) microphones and boxcar-decimates each channel.
- Converts each result to signed wordsize samples and presents them on main/sub, with a one-cycle start_sample strobe and the start level.
- Enforces a minimum spacing between strobes so the reducer's per-sample FIR/LMS sequence always completes; violations are flagged as overrun.

Parameters:
- wordsize, 8: width of the signed main/sub outputs; must match the reducer.
- adc_width, 12: width of the unsigned offset-binary ADC words; must be greater than wordsize.
- log2_decim, 2: decimation factor is 2^log2_decim ADC samples per output sample.
- min_gap, 40: minimum clock cycles between consecutive start_sample pulses; at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = acquire, 0 = idle and discard partial accumulation.
- adc_valid  in  1  one-cycle qualifier for adc_main/adc_sub.
- adc_main  in  adc_width  main mic ADC word, offset-binary.
- adc_sub  in  adc_width  reference mic ADC word, offset-binary.
- main  out  wordsize  signed decimated main sample.
- sub  out  wordsize  signed decimated reference sample.
- start_sample  out  1  one-cycle strobe; main/sub valid and new in that cycle.
- start  out  1  level; high from the first strobe after enable rises until enable falls.
- overrun  out  1  sticky; a completed sample was dropped for gap violation.

Behaviour:
- Reset: main=0, sub=0, start_sample=0, start=0, overrun=0, accumulators=0, sample counter=0, state IDLE. The gap timer is preloaded so the first emission is allowed.
- States:
  - IDLE: enable=0. Accumulators and counter are held at 0; adc_valid is ignored.
  - ACCUM: enable=1.
  - IDLE->ACCUM on enable=1. ACCUM->IDLE on enable=0, taking effect at the next edge.
- Priority: enable=0 beats a coincident adc_valid; that sample is discarded.
- Leaving ACCUM:
  - Partial sums are discarded.
  - start and overrun clear at the next edge.
  - main/sub hold their last emitted values.
- Input conversion: invert the MSB (offset-binary to two's complement), then sign-extend into a (adc_width+log2_decim)-bit accumulator.
- Accumulation: each adc_valid in ACCUM adds both converted words and increments the counter. The counter wraps 2^log2_decim-1 -> 0.
- Completion: the adc_valid that brings the counter to 2^log2_decim (the final sample is included in the sum).
- Output arithmetic, per channel:
  - avg = sum >>> log2_decim (arithmetic shift, floor).
  - r = avg + 2^(adc_width-wordsize-1).
  - out = r >>> (adc_width-wordsize), saturated to [-2^(wordsize-1), 2^(wordsize-1)-1].
- Latency: completion adc_valid sampled at edge N. main, sub and start_sample=1 appear after edge N and last exactly one cycle for the strobe.
- start rises together with the first strobe after entering ACCUM.
- Gap rule: a strobe may occur only when at least min_gap cycles separate it from the previous strobe; a pulse at cycle t is followed earliest at t+min_gap.
- Early completion: if a completion arrives earlier than that:
  - no strobe is issued and main/sub are unchanged;
  - overrun is set;
  - accumulators and counter restart at 0.
- The gap timer saturates; it does not wrap.
- Reset asserted mid-operation returns everything to the reset values immediately (asynchronous).
- start_sample is never asserted in IDLE or while rst_n=0.

Test Plan:
- Defaults, enable=1, four adc_valid with adc_main=adc_sub=0x800 -> one strobe one cycle after the 4th valid; main=0, sub=0; start rises with the strobe.
- adc_main 0xFFF x4, adc_sub 0x000 x4 -> main=127 (2055>>4 saturated), sub=-128.
- adc_main 0x800,0x808,0x810,0x818 -> sum 48, avg 12, main=1; adc_sub 0x810 x4 -> sub=1.
- adc_valid every cycle, enable=1 for 200 cycles, min_gap=40 -> strobes exactly 40 cycles apart; overrun=1 after the first dropped completion (4 cycles after the first strobe); main/sub unchanged between strobes.
- Drop enable after 2 of 4 samples, re-enable, supply 4 samples of 0x810 -> one strobe with main=1 (partial discarded); start and overrun low during the idle gap.
- Assert rst_n=0 mid-accumulation with start=1, overrun=1 -> all outputs 0 asynchronously. After release, the first completion strobes immediately with no gap wait.
